// File: rtl/multiplicador_acum_7bit.sv
// -----------------------------------------------------------------------------
// multiplicador_acum_7bit
//
// Purpose:
//   Rebuilds a dividend A = Q*B + R from quotient, divisor and remainder.
//   It uses a shift-add datapath that retires one multiplier bit per clock.
//   It is the round-trip partner of divisor_7bit and uses the same start/done
//   handshake as the divider.
//
// Ports:
//   clk    in   1     system clock, rising edge
//   rst_n  in   1     asynchronous active-low reset
//   start  in   1     request, sampled only while idle
//   Q      in   W     quotient (multiplier)
//   B      in   W     divisor (multiplicand)
//   R      in   W     remainder (addend, preloaded into the accumulator)
//   A      out  2*W   reconstructed dividend; held until the next run completes
//   busy   out  1     high while running and during the done cycle
//   done   out  1     one-cycle completion pulse
//   err    out  1     remainder-range flag (R >= B), captured at accept
//
// Configuration:
//   REMAINDER_CHECK_EN  when defined, err reports R >= B for the accepted
//                       operands, so B = 0 always flags. When undefined, err
//                       is tied low and no compare logic is built.
//
// States:
//   state | meaning
//   IDLE  | waiting for start; operands are loaded on the accepting edge
//   RUN   | W shift-add iterations, one per clock
//   DONE  | result valid on A, done pulses for this single cycle
// -----------------------------------------------------------------------------
module multiplicador_acum_7bit #(
  parameter int W = 7
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic [W-1:0]   Q,
  input  logic [W-1:0]   B,
  input  logic [W-1:0]   R,
  output logic [2*W-1:0] A,
  output logic           busy,
  output logic           done,
  output logic           err
);

  localparam int CW = $clog2(W + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(W - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [2*W-1:0] acc;
  logic [2*W-1:0] mcand;
  logic [W-1:0]   mplier;
  logic [CW-1:0]  cnt;

  logic           load;
  logic           step;
  logic           finish;
  logic [2*W-1:0] acc_sum;

  // The accumulator starts at R, so the addend costs no extra cycle.
  // The worst case (2^W-1)^2 + (2^W-1) still fits in 2W bits.
  assign acc_sum = acc + (mplier[0] ? mcand : '0);

  // ---------------------------------------------------------------------------
  // FSM state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM next-state and control outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    step      = 1'b0;
    finish    = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;

    unique case (state)
      IDLE: begin
        if (start) begin
          load      = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        busy = 1'b1;
        step = 1'b1;
        if (cnt == CNT_LAST) begin
          finish    = 1'b1;
          state_nxt = DONE;
        end
      end
      DONE: begin
        busy      = 1'b1;
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Shift-add datapath
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      cnt    <= '0;
    end else if (load) begin
      acc    <= {{W{1'b0}}, R};
      mcand  <= {{W{1'b0}}, B};
      mplier <= Q;
      cnt    <= '0;
    end else if (step) begin
      acc    <= acc_sum;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt + CW'(1);
    end
  end

  // The result register takes the last partial sum directly. That way A
  // becomes valid on the same edge that enters DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      A <= '0;
    end else if (finish) begin
      A <= acc_sum;
    end
  end

  // ---------------------------------------------------------------------------
  // Remainder-range flag
  // ---------------------------------------------------------------------------
`ifdef REMAINDER_CHECK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err <= 1'b0;
    end else if (load) begin
      err <= (R >= B);
    end
  end
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_multiplicador_acum_7bit.sv
module tb_multiplicador_acum_7bit;

  localparam int W = 7;

  logic           clk;
  logic           rst_n;
  logic           start;
  logic [W-1:0]   Q;
  logic [W-1:0]   B;
  logic [W-1:0]   R;
  logic [2*W-1:0] A;
  logic           busy;
  logic           done;
  logic           err;

  int n_checks;
  int n_errors;

  multiplicador_acum_7bit #(.W(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .Q     (Q),
    .B     (B),
    .R     (R),
    .A     (A),
    .busy  (busy),
    .done  (done),
    .err   (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int unsigned got, input int unsigned exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int unsigned ref_a(input int unsigned q, input int unsigned b,
                                        input int unsigned r);
    return q * b + r;
  endfunction

  function automatic int unsigned ref_err(input int unsigned r, input int unsigned b);
`ifdef REMAINDER_CHECK_EN
    return (r >= b) ? 1 : 0;
`else
    return 0;
`endif
  endfunction

  // One complete transaction. Start is driven on a falling edge and dropped one
  // clock later. The operands are then scrambled while the run is in progress.
  // Done must show at the 8th falling edge after start is raised.
  task automatic run_op(input string tag, input int unsigned q, input int unsigned b,
                        input int unsigned r);
    int unsigned exp_a;
    int unsigned exp_e;
    int          lat;
    bit          seen;
    exp_a = ref_a(q, b, r);
    exp_e = ref_err(r, b);
    @(negedge clk);
    start = 1'b1;
    Q = W'(q);
    B = W'(b);
    R = W'(r);
    seen = 1'b0;
    lat  = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (k == 1) begin
        start = 1'b0;
        chk({tag, "_busy_run"}, busy, 1);
      end
      if (k == 2) begin
        Q = W'($urandom);
        B = W'($urandom);
        R = W'($urandom);
      end
      if (done) begin
        seen = 1'b1;
        lat  = k;
        break;
      end
    end
    chk({tag, "_done_seen"}, seen, 1);
    if (seen) begin
      chk({tag, "_latency"}, lat, W + 1);
      chk({tag, "_A"}, A, exp_a);
      chk({tag, "_err"}, err, exp_e);
      @(negedge clk);
      chk({tag, "_done_pulse"}, done, 0);
      chk({tag, "_busy_after"}, busy, 0);
      repeat (2) @(negedge clk);
      chk({tag, "_A_hold"}, A, exp_a);
      chk({tag, "_err_hold"}, err, exp_e);
    end
  endtask

  initial begin
    int          pulses;
    int          first_t;
    int          second_t;
    int unsigned a_at_done;
    int unsigned q;
    int unsigned b;
    int unsigned r;

    n_checks = 0;
    n_errors = 0;
    rst_n = 1'b0;
    start = 1'b0;
    Q = '0;
    B = '0;
    R = '0;
    repeat (3) @(negedge clk);
    chk("rst_A", A, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_busy", busy, 0);

    // Directed cases.
    run_op("q0_b5", 0, 5, 0);
    run_op("q41_b3", 41, 3, 0);
    run_op("q18_b7_r1", 18, 7, 1);
    run_op("max", 127, 127, 127);
    run_op("b0_r9", 77, 0, 9);
    run_op("q0_r5", 0, 33, 5);
    run_op("err_set", 2, 3, 5);
    run_op("err_clr", 2, 3, 2);

    // A start pulse that arrives mid-run must be ignored.
    @(negedge clk);
    start = 1'b1; Q = 7'd5; B = 7'd5; R = 7'd0;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    start = 1'b1; Q = 7'd9; B = 7'd9; R = 7'd0;
    @(negedge clk);
    start = 1'b0;
    pulses = 0;
    a_at_done = 0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (done) begin
        if (pulses == 0) a_at_done = A;
        pulses++;
      end
    end
    chk("restart_pulses", pulses, 1);
    chk("restart_A", a_at_done, 25);

    // Reset in the middle of a run aborts it.
    @(negedge clk);
    start = 1'b1; Q = 7'd41; B = 7'd3; R = 7'd0;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_A", A, 0);
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_err", err, 0);
    @(negedge clk);
    rst_n = 1'b1;
    pulses = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (done) pulses++;
    end
    chk("abort_no_done", pulses, 0);
    run_op("after_abort", 41, 3, 0);

    // With start held high, the block restarts on every return to IDLE.
    // Successive done pulses are therefore 9 clocks apart.
    @(negedge clk);
    start = 1'b1; Q = 7'd18; B = 7'd7; R = 7'd1;
    pulses   = 0;
    first_t  = 0;
    second_t = 0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (done) begin
        pulses++;
        chk("hold_A", A, 127);
        if (pulses == 1) first_t = k;
        if (pulses == 2) begin
          second_t = k;
          break;
        end
      end
    end
    start = 1'b0;
    chk("hold_pulses", pulses, 2);
    chk("hold_spacing", second_t - first_t, 9);
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (!busy) break;
    end
    chk("hold_drain", busy, 0);

    // Randomized operands checked against plain arithmetic.
    for (int n = 0; n < 30; n++) begin
      q = $urandom_range(0, 127);
      b = $urandom_range(0, 127);
      r = $urandom_range(0, 127);
      run_op($sformatf("rnd%0d", n), q, b, r);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
